// File: rtl/mem_transfer_scheduler.sv
// Host output memory sequencer: splits enqueued buffers into fixed-size write
// requests, tracks in-order completions and raises one interrupt per buffer.
module mem_transfer_scheduler #(
   parameter int TRANSFER_BYTES   = 65536,
   parameter int MAX_BUFFERS      = 256,
   parameter int MAX_OUTSTANDING  = 8,
   parameter int VADDR_BITS       = 64,
   parameter int BUFFER_SIZE_BITS = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     buf_valid,
   output logic                                     buf_ready,
   input  logic [VADDR_BITS+BUFFER_SIZE_BITS-1:0]   buf_data,
   output logic                                     req_valid,
   input  logic                                     req_ready,
   output logic [VADDR_BITS-1:0]                    req_vaddr,
   output logic                                     req_last,
   input  logic                                     ack_valid,
   output logic                                     ack_ready,
   output logic                                     irq_valid,
   input  logic                                     irq_ready,
   output logic [31:0]                              irq_value,
   output logic [$clog2(MAX_BUFFERS+1)-1:0]         queue_count,
   output logic                                     err_ack
);

   localparam int SB = BUFFER_SIZE_BITS;
   localparam int BW = VADDR_BITS + SB;
   localparam int SH = $clog2(TRANSFER_BYTES);
   localparam int QW = $clog2(MAX_BUFFERS + 1);
   localparam int PW = $clog2(MAX_BUFFERS);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(MAX_OUTSTANDING);

   localparam logic [0:0]    S_IDLE  = 1'b0;
   localparam logic [0:0]    S_ISSUE = 1'b1;
   localparam logic [QW-1:0] Q_MAX   = QW'(MAX_BUFFERS);
   localparam logic [QW-1:0] Q_ONE   = QW'(1);
   localparam logic [OW-1:0] O_MAX   = OW'(MAX_OUTSTANDING);
   localparam logic [OW-1:0] O_ONE   = OW'(1);
   localparam logic [SB-1:0] S_ONE   = SB'(1);
   localparam logic [PW-1:0] P_ONE   = PW'(1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   logic [BW-1:0]         r_bmem [MAX_BUFFERS];
   logic [PW-1:0]         r_bwr, r_brd;
   logic [QW-1:0]         r_qcnt;
   logic [SB-1:0]         r_cmem [MAX_OUTSTANDING];
   logic [CW-1:0]         r_cwr, r_crd;
   logic [OW-1:0]         r_ccnt;
   logic [0:0]            r_state;
   logic [VADDR_BITS-1:0] r_base;
   logic [SB-1:0]         r_idx, r_rem, r_done;
   logic [OW-1:0]         r_outst;
   logic [3:0]            r_seq;
   logic                  r_irq_valid;
   logic [31:0]           r_irq_value;
   logic                  r_err;

   logic [BW-1:0]         w_head;
   logic [VADDR_BITS-1:0] w_head_vaddr;
   logic [SB-1:0]         w_head_size;
   logic [SB-1:0]         w_chead;
   logic [27:0]           w_bytes;
   logic                  w_push, w_pop, w_load, w_cfull;
   logic                  w_req_fire, w_ack_in, w_ack_fire, w_complete;

   assign w_head       = r_bmem[r_brd];
   assign w_head_vaddr = w_head[BW-1:SB];
   assign w_head_size  = w_head[SB-1:0];
   assign w_chead      = r_cmem[r_crd];
   assign w_bytes      = 28'(w_chead << SH);

   assign w_push     = buf_valid && buf_ready;
   assign w_cfull    = (r_ccnt == O_MAX);
   assign w_pop      = (r_state == S_IDLE) && (r_qcnt != '0) && !w_cfull;
   assign w_load     = w_pop && (w_head_size != '0);
   assign w_req_fire = req_valid && req_ready;
   assign w_ack_in   = ack_valid && ack_ready;
   assign w_ack_fire = w_ack_in && (r_outst != '0);
   assign w_complete = w_ack_fire && ((r_done + S_ONE) == w_chead);

   assign buf_ready   = !rst && (r_qcnt < Q_MAX);
   assign req_valid   = (r_state == S_ISSUE) && (r_outst < O_MAX);
   assign req_vaddr   = r_base + (VADDR_BITS'(r_idx) << SH);
   assign req_last    = (r_rem == S_ONE);
   assign ack_ready   = !(r_irq_valid && !irq_ready);
   assign irq_valid   = r_irq_valid;
   assign irq_value   = r_irq_value;
   assign queue_count = r_qcnt;
   assign err_ack     = r_err;

   always_ff @(posedge clk) begin
      if (w_push) r_bmem[r_bwr] <= buf_data;
      if (w_load) r_cmem[r_cwr] <= w_head_size;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bwr       <= '0;
         r_brd       <= '0;
         r_qcnt      <= '0;
         r_cwr       <= '0;
         r_crd       <= '0;
         r_ccnt      <= '0;
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_idx       <= '0;
         r_rem       <= '0;
         r_done      <= '0;
         r_outst     <= '0;
         r_seq       <= '0;
         r_irq_valid <= 1'b0;
         r_irq_value <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_push) r_bwr <= r_bwr + P_ONE;
         if (w_pop)  r_brd <= r_brd + P_ONE;
         if (w_push && !w_pop)      r_qcnt <= r_qcnt + Q_ONE;
         else if (!w_push && w_pop) r_qcnt <= r_qcnt - Q_ONE;

         if (w_load)     r_cwr <= r_cwr + C_ONE;
         if (w_complete) r_crd <= r_crd + C_ONE;
         if (w_load && !w_complete)      r_ccnt <= r_ccnt + O_ONE;
         else if (!w_load && w_complete) r_ccnt <= r_ccnt - O_ONE;

         if (w_req_fire && !w_ack_fire)      r_outst <= r_outst + O_ONE;
         else if (!w_req_fire && w_ack_fire) r_outst <= r_outst - O_ONE;

         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_base  <= w_head_vaddr;
                  r_rem   <= w_head_size;
                  r_idx   <= '0;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (w_req_fire) begin
                  r_idx <= r_idx + S_ONE;
                  r_rem <= r_rem - S_ONE;
                  if (r_rem == S_ONE) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_ack_fire) r_done <= w_complete ? '0 : r_done + S_ONE;

         // a completion in the accept cycle replaces the old irq, never drops it
         if (w_complete) begin
            r_irq_valid <= 1'b1;
            r_irq_value <= {r_seq, w_bytes};
            r_seq       <= r_seq + 4'd1;
         end else if (r_irq_valid && irq_ready) begin
            r_irq_valid <= 1'b0;
         end

         if (w_ack_in && (r_outst == '0)) r_err <= 1'b1;
      end
   end

endmodule
